// File: rtl/uart_byte_rx_if.sv
// Byte-level receive side of the serial link toward the DDS command parser.
// The slave modport is the receiver itself; the master modport is whatever
// drives the serial line and consumes the recovered bytes.
interface uart_byte_rx_if;
    logic       rxd;         // raw asynchronous serial line, idle high
    logic [7:0] rx_data;     // last correctly framed byte, held until the next one
    logic       data_valid;  // one-cycle pulse: rx_data is new this cycle
    logic       frame_err;   // one-cycle pulse: stop bit sampled low
    logic       busy;        // receiver is inside a frame

    modport master (
        output rxd,
        input  rx_data,
        input  data_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rxd,
        output rx_data,
        output data_valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 serial byte receiver.
// The raw line is brought into the clock domain by a two-flop synchronizer;
// a three-sample history of the synchronized line feeds a majority vote that
// decides the start bit, every data bit and the stop bit. Each recovered
// byte is presented with a single-cycle data_valid; a low stop bit yields a
// single-cycle frame_err and leaves rx_data untouched.
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 434    // clocks per bit, must be >= 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_byte_rx_if.slave  bus
);

    // Counter only ever needs to reach CLKS_PER_BIT-1.
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int H     = CLKS_PER_BIT / 2;

    // START decision happens on the H-th clock spent in START (count runs
    // 0..H-1), which lands the vote near the centre of the start bit.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(H - 1);
    // DATA/STOP decisions happen once per full bit period.
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_reg;
    logic             m1_reg;
    logic             m2_reg;
    logic [2:0]       hist_reg;     // hist_reg[0] is the previous m2 sample
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       idx_reg;
    logic [7:0]       shift_reg;
    logic [7:0]       data_reg;
    logic             valid_reg;
    logic             ferr_reg;
    logic             busy_reg;

    logic             majority;
    logic             start_edge;

    // Two-flop synchronizer plus sample history; everything rests at the
    // idle line level so leaving reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            m1_reg   <= 1'b1;
            m2_reg   <= 1'b1;
            hist_reg <= 3'b111;
        end else begin
            m1_reg   <= bus.rxd;
            m2_reg   <= m1_reg;
            hist_reg <= {hist_reg[1:0], m2_reg};
        end
    end

    // Two-of-three vote over the history; a single-cycle spike cannot win.
    assign majority = (hist_reg[0] & hist_reg[1]) |
                      (hist_reg[0] & hist_reg[2]) |
                      (hist_reg[1] & hist_reg[2]);

    // Only a 1->0 transition starts a frame, so a held-low break never
    // retriggers the receiver.
    assign start_edge = ~m2_reg & hist_reg[0];

    // Receive FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (start_edge) begin
                        state_reg <= START;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                    end
                end

                START: begin
                    if (cnt_reg == START_LAST) begin
                        cnt_reg <= '0;
                        if (majority) begin
                            // Line came back high: glitch, not a start bit.
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg <= DATA;
                            idx_reg   <= '0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg   <= '0;
                        shift_reg <= {majority, shift_reg[7:1]};
                        idx_reg   <= idx_reg + 3'd1;
                        if (idx_reg == 3'd7) begin
                            state_reg <= STOP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        // Leave at mid stop bit so a back-to-back start
                        // edge is caught in IDLE.
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        if (majority) begin
                            data_reg  <= shift_reg;
                            valid_reg <= 1'b1;
                        end else begin
                            ferr_reg  <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // Registered outputs onto the interface.
    assign bus.rx_data    = data_reg;
    assign bus.data_valid = valid_reg;
    assign bus.frame_err  = ferr_reg;
    assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx with CLKS_PER_BIT=16. Each driven frame pushes its
// expected outcome (pulse kind, rx_data, cycle of the pulse) onto a queue;
// a monitor on the falling edge pops and compares whenever a pulse appears.
module tb_uart_byte_rx;

    localparam int C = 16;
    localparam int H = C / 2;
    localparam int LAT = H + 9 * C + 3;   // edges from line fall to pulse

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_byte_rx_if rx_if ();

    uart_byte_rx #(.CLKS_PER_BIT(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rx_if)
    );

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] last_good = 8'h00;
    bit         prev_pulse = 1'b0;

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_if.data_valid === 1'b1 || rx_if.frame_err === 1'b1) begin
            check_eq("exclusive", 32'(rx_if.data_valid & rx_if.frame_err), 32'd0);
            check_eq("pulse_width", 32'(prev_pulse), 32'd0);
            if (sb.size() == 0) begin
                check_eq("spurious", 32'({rx_if.data_valid, rx_if.frame_err}), 32'd0);
            end else begin
                e = sb.pop_front();
                $display("rx %s data=0x%02h cycle=%0d (want cycle %0d)",
                         rx_if.frame_err ? "frame_err" : "byte", rx_if.rx_data, cyc, e.at);
                check_eq("kind_ferr", 32'(rx_if.frame_err), 32'(e.is_err));
                check_eq("kind_valid", 32'(rx_if.data_valid), 32'(!e.is_err));
                check_eq("rx_data", 32'(rx_if.rx_data), 32'(e.data));
                check_eq("latency", 32'(cyc), 32'(e.at));
            end
        end
        prev_pulse = (rx_if.data_valid === 1'b1) || (rx_if.frame_err === 1'b1);
    end

    // Wait n rising edges, then settle 1 time unit past the edge.
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame. spike_bit inverts the line for one cycle at that
    // bit's sample point; abort_bit pulses rst mid-way through that bit.
    task automatic send(input logic [7:0] b, input bit stop_val,
                        input int spike_bit, input int abort_bit);
        int t0;
        t0 = cyc;
        rx_if.rxd = 1'b0;
        hold(C);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_bit) begin
                hold(H);
                rst = 1'b1;
                rx_if.rxd = 1'b1;
                hold(1);
                rst = 1'b0;
                check_eq("rst_data", 32'(rx_if.rx_data), 32'd0);
                check_eq("rst_busy", 32'(rx_if.busy), 32'd0);
                check_eq("rst_valid", 32'(rx_if.data_valid), 32'd0);
                check_eq("rst_ferr", 32'(rx_if.frame_err), 32'd0);
                last_good = 8'h00;
                $display("frame 0x%02h abandoned by reset at cycle %0d", b, cyc);
                return;
            end
            if (i == spike_bit) begin
                rx_if.rxd = b[i];
                hold(H - 1);
                rx_if.rxd = ~b[i];
                hold(1);
                rx_if.rxd = b[i];
                hold(C - H);
            end else begin
                rx_if.rxd = b[i];
                hold(C);
            end
        end
        sb.push_back('{is_err: !stop_val, data: (stop_val ? b : last_good), at: t0 + LAT});
        if (stop_val) last_good = b;
        rx_if.rxd = stop_val;
        hold(C);
    endtask

    initial begin
        int t;
        rx_if.rxd = 1'b1;
        rst = 1'b1;
        hold(2);
        rst = 1'b0;

        // Idle line after reset: outputs stay at reset values.
        for (int i = 0; i < 20; i++) begin
            hold(1);
            check_eq("idle_data", 32'(rx_if.rx_data), 32'd0);
            check_eq("idle_valid", 32'(rx_if.data_valid), 32'd0);
            check_eq("idle_ferr", 32'(rx_if.frame_err), 32'd0);
            check_eq("idle_busy", 32'(rx_if.busy), 32'd0);
        end

        // Single 'F'.
        send(8'h46, 1'b1, -1, -1);
        hold(C);

        // Back-to-back frames, the last one with a spike in bit 3.
        send(8'h41, 1'b1, -1, -1);
        send(8'h03, 1'b1, -1, -1);
        send(8'hFF, 1'b1, -1, -1);
        send(8'h00, 1'b1, 3, -1);
        hold(2 * C);

        // Four-cycle low glitch: busy for edges 3..H+2, then back to idle.
        t = cyc;
        rx_if.rxd = 1'b0;
        for (int k = 0; k < 34; k++) begin
            if (k == 4) rx_if.rxd = 1'b1;
            hold(1);
            check_eq("glitch_busy", 32'(rx_if.busy),
                     32'((cyc >= t + 3) && (cyc < t + H + 3)));
        end

        // Low stop bit followed by a break; no retrigger while held low.
        send(8'h55, 1'b0, -1, -1);
        rx_if.rxd = 1'b0;
        for (int k = 0; k < 40; k++) begin
            hold(1);
            check_eq("break_busy", 32'(rx_if.busy), 32'd0);
        end
        rx_if.rxd = 1'b1;
        hold(C);
        send(8'h12, 1'b1, -1, -1);
        hold(C);

        // Reset in data bit 4, then a clean frame.
        send(8'h3C, 1'b1, -1, 4);
        hold(2 * C);
        send(8'hA5, 1'b1, -1, -1);
        hold(C);

        // Every expected pulse must have been seen.
        for (int i = 0; i < 500 && sb.size() > 0; i++) hold(1);
        check_eq("drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
